// File: rtl/qick_xcom_cmd_arb.sv
// -----------------------------------------------------------------------------
// qick_xcom_cmd_arb
//
// Purpose:
//   Arbitrates XCOM command issue between the tProc peripheral port and the
//   PS/AXI command port. Each source feeds a small FIFO. One command at a time
//   is handed to qick_xcom over a 4-phase req/ack pair. The pair is chosen by
//   op[4]: 1 selects the network pair, 0 selects the local pair.
//
// Ports (all in c_clk_i):
//   c_clk_i, c_rst_i            clock, synchronous active-high reset
//   tp_en_i/tp_op_i/tp_dt_i     tProc command strobe, opcode, data
//   tp_rdy_o                    tProc queue not full (registered)
//   ps_en_i/ps_op_i/ps_dt_i     PS command strobe, opcode, data
//   ps_rdy_o                    PS queue not full (registered)
//   cfg_prio_i                  0 = round-robin, 1 = tProc fixed priority
//   err_clr_i                   clears err_o
//   cmd_loc_req_o/cmd_loc_ack_i local command handshake
//   cmd_net_req_o/cmd_net_ack_i network command handshake
//   cmd_op_o                    {src(1=PS), 2'b00, op[4:0]}, stable while req high
//   cmd_dt_o                    command data, stable while req high
//   busy_o                      FSM not idle or any queue non-empty
//   err_o                       sticky: a strobe hit a full queue
//   cmd_cnt_o                   completed commands (wraps)
//   drop_cnt_o                  dropped commands (wraps)
// -----------------------------------------------------------------------------
module qick_xcom_cmd_arb #(
  parameter int QD    = 2,
  parameter int CNT_W = 8
) (
  input  logic             c_clk_i,
  input  logic             c_rst_i,
  input  logic             tp_en_i,
  input  logic [4:0]       tp_op_i,
  input  logic [31:0]      tp_dt_i,
  output logic             tp_rdy_o,
  input  logic             ps_en_i,
  input  logic [4:0]       ps_op_i,
  input  logic [31:0]      ps_dt_i,
  output logic             ps_rdy_o,
  input  logic             cfg_prio_i,
  input  logic             err_clr_i,
  output logic             cmd_loc_req_o,
  input  logic             cmd_loc_ack_i,
  output logic             cmd_net_req_o,
  input  logic             cmd_net_ack_i,
  output logic [7:0]       cmd_op_o,
  output logic [31:0]      cmd_dt_o,
  output logic             busy_o,
  output logic             err_o,
  output logic [CNT_W-1:0] cmd_cnt_o,
  output logic [CNT_W-1:0] drop_cnt_o
);

  localparam int PW = $clog2(QD);
  localparam int EW = 37;  // {op[4:0], dt[31:0]}

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WACK
  } state_t;

  // Index 0 = tProc, index 1 = PS.
  logic [1:0][EW-1:0] q_din;
  logic [1:0][EW-1:0] q_head;
  logic [1:0]         q_push_req;
  logic [1:0]         q_pop;
  logic [1:0]         q_empty;
  logic [1:0]         q_full;
  logic [1:0]         q_accept;
  logic [1:0]         q_drop;

  assign q_push_req = {ps_en_i, tp_en_i};
  assign q_din[0]   = {tp_op_i, tp_dt_i};
  assign q_din[1]   = {ps_op_i, ps_dt_i};

  // ---------------------------------------------------------------------------
  // Per-source FIFOs
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_q
      logic [EW-1:0] mem [QD];
      logic [PW-1:0] wr_ptr_reg;
      logic [PW-1:0] rd_ptr_reg;
      logic [PW:0]   cnt_reg;
      logic [PW:0]   cnt_next;
      logic          full_reg;

      // A pop frees a slot in the same cycle, so a full queue still accepts a
      // strobe when the arbiter pops it on that edge.
      assign q_accept[gi] = q_push_req[gi] && (!full_reg || q_pop[gi]);
      assign q_drop[gi]   = q_push_req[gi] && full_reg && !q_pop[gi];
      assign q_empty[gi]  = (cnt_reg == '0);
      assign q_full[gi]   = full_reg;
      assign q_head[gi]   = mem[rd_ptr_reg];
      assign cnt_next     = cnt_reg + (PW+1)'(q_accept[gi]) - (PW+1)'(q_pop[gi]);

      always_ff @(posedge c_clk_i) begin
        if (q_accept[gi]) begin
          mem[wr_ptr_reg] <= q_din[gi];
        end
      end

      always_ff @(posedge c_clk_i) begin
        if (c_rst_i) begin
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
          cnt_reg    <= '0;
          full_reg   <= 1'b0;
        end else begin
          if (q_accept[gi]) wr_ptr_reg <= wr_ptr_reg + PW'(1);
          if (q_pop[gi])    rd_ptr_reg <= rd_ptr_reg + PW'(1);
          cnt_reg  <= cnt_next;
          full_reg <= (cnt_next == (PW+1)'(QD));
        end
      end
    end
  endgenerate

  assign tp_rdy_o = !q_full[0];
  assign ps_rdy_o = !q_full[1];

  // ---------------------------------------------------------------------------
  // Issue FSM
  // ---------------------------------------------------------------------------
  state_t            state_reg, state_next;
  logic              rr_ps_reg;      // on a tie in round-robin mode, PS wins when set
  logic              net_reg;        // path of the command in flight
  logic              loc_req_reg, net_req_reg;
  logic [7:0]        op_reg;
  logic [31:0]       dt_reg;
  logic              err_reg;
  logic [CNT_W-1:0]  cmd_cnt_reg, drop_cnt_reg;

  logic              grant_ps;
  logic              issue;
  logic              done;
  logic              sel_ack;
  logic [EW-1:0]     sel_head;

  always_comb begin
    grant_ps = 1'b0;
    if (q_empty[0])      grant_ps = 1'b1;
    else if (q_empty[1]) grant_ps = 1'b0;
    else                 grant_ps = cfg_prio_i ? 1'b0 : rr_ps_reg;
  end

  assign sel_head = q_head[grant_ps];
  assign sel_ack  = net_reg ? cmd_net_ack_i : cmd_loc_ack_i;

  always_comb begin
    state_next = state_reg;
    issue      = 1'b0;
    done       = 1'b0;
    q_pop      = 2'b00;
    case (state_reg)
      ST_IDLE: begin
        if (!(&q_empty)) begin
          issue      = 1'b1;
          q_pop      = grant_ps ? 2'b10 : 2'b01;
          state_next = ST_REQ;
        end
      end
      ST_REQ: begin
        if (sel_ack) state_next = ST_WACK;
      end
      ST_WACK: begin
        if (!sel_ack) begin
          done       = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge c_clk_i) begin
    if (c_rst_i) begin
      state_reg    <= ST_IDLE;
      rr_ps_reg    <= 1'b0;
      net_reg      <= 1'b0;
      loc_req_reg  <= 1'b0;
      net_req_reg  <= 1'b0;
      op_reg       <= '0;
      dt_reg       <= '0;
      err_reg      <= 1'b0;
      cmd_cnt_reg  <= '0;
      drop_cnt_reg <= '0;
    end else begin
      state_reg <= state_next;

      if (issue) begin
        op_reg      <= {grant_ps, 2'b00, sel_head[36:32]};
        dt_reg      <= sel_head[31:0];
        net_reg     <= sel_head[36];
        loc_req_reg <= !sel_head[36];
        net_req_reg <= sel_head[36];
        rr_ps_reg   <= !grant_ps;
      end else if (state_reg == ST_REQ && sel_ack) begin
        loc_req_reg <= 1'b0;
        net_req_reg <= 1'b0;
      end

      if (done) cmd_cnt_reg <= cmd_cnt_reg + CNT_W'(1);

      // Both sources may drop on the same edge.
      drop_cnt_reg <= drop_cnt_reg + CNT_W'(q_drop[0]) + CNT_W'(q_drop[1]);

      // A new drop wins over a clear on the same edge.
      if (|q_drop)        err_reg <= 1'b1;
      else if (err_clr_i) err_reg <= 1'b0;
    end
  end

  assign cmd_loc_req_o = loc_req_reg;
  assign cmd_net_req_o = net_req_reg;
  assign cmd_op_o      = op_reg;
  assign cmd_dt_o      = dt_reg;
  assign err_o         = err_reg;
  assign cmd_cnt_o     = cmd_cnt_reg;
  assign drop_cnt_o    = drop_cnt_reg;
  assign busy_o        = (state_reg != ST_IDLE) || !(&q_empty);

endmodule
